// File: rtl/ssm_cfg_pkg.sv
// ssm_cfg_pkg: shared SSM tiling configuration and scheduler state encoding
//   H_TILE/P_TILE/N_TILE  datapath pass shape
//   N_TOTAL/H_TOTAL/P_TOTAL  full problem shape
//   TPG   tiles per (h,p) group, NGRP  groups per step
package ssm_cfg_pkg;
    localparam int H_TILE  = 1;
    localparam int P_TILE  = 1;
    localparam int N_TILE  = 128;
    localparam int N_TOTAL = 128;
    localparam int H_TOTAL = 24;
    localparam int P_TOTAL = 64;
    localparam int TPG     = (N_TOTAL + N_TILE - 1) / N_TILE;
    localparam int NGRP    = (H_TOTAL / H_TILE) * (P_TOTAL / P_TILE);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} sched_state_t;
endpackage

// File: rtl/tile_vld_delay.sv
// tile_vld_delay: LAT-deep 1-bit shift register with async clear
//   clk, rstn  clock, async active-low clear
//   d          input strobe
//   q          d delayed by exactly LAT cycles
module tile_vld_delay #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);
    logic [LAT-1:0] sr;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
        end
    end
    assign q = sr[LAT-1];
endmodule

// File: rtl/ssm_tile_sched.sv
// ssm_tile_sched: walks all (h,p) tile groups of one SSM step with credit-limited issue
//   clk, rstn          clock, async active-low reset
//   start_i            run one step; ignored while busy
//   busy_o, done_o     step in progress / 1-cycle completion pulse
//   rd_en_o            tile-buffer read strobe for (rd_grp_o, rd_tile_o)
//   tile_valid_o       rd_en_o delayed by RD_LAT into the datapath
//   tile_ready_i       datapath ready; gates issue
//   y_valid_i          datapath group result
//   y_wr_en_o/grp_o    y writeback strobe and group index
//   err_o              sticky: result seen with nothing outstanding
module ssm_tile_sched #(
    parameter int H_TILE       = ssm_cfg_pkg::H_TILE,
    parameter int P_TILE       = ssm_cfg_pkg::P_TILE,
    parameter int N_TILE       = ssm_cfg_pkg::N_TILE,
    parameter int N_TOTAL      = ssm_cfg_pkg::N_TOTAL,
    parameter int H_TOTAL      = ssm_cfg_pkg::H_TOTAL,
    parameter int P_TOTAL      = ssm_cfg_pkg::P_TOTAL,
    parameter int RD_LAT       = 2,
    parameter int MAX_INFLIGHT = 4,
    localparam int TPG  = (N_TOTAL + N_TILE - 1) / N_TILE,
    localparam int NGRP = (H_TOTAL / H_TILE) * (P_TOTAL / P_TILE),
    localparam int GW   = $clog2(NGRP + 1),
    localparam int TW   = $clog2(TPG + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          rd_en_o,
    output logic [GW-1:0] rd_grp_o,
    output logic [TW-1:0] rd_tile_o,
    output logic          tile_valid_o,
    input  logic          tile_ready_i,
    input  logic          y_valid_i,
    output logic          y_wr_en_o,
    output logic [GW-1:0] y_wr_grp_o,
    output logic          err_o
);
    import ssm_cfg_pkg::*;

    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IW-1:0] MAX_I  = IW'(MAX_INFLIGHT);
    localparam logic [TW-1:0] LAST_T = TW'(TPG - 1);
    localparam logic [GW-1:0] LAST_G = GW'(NGRP - 1);
    localparam logic [GW-1:0] N_G    = GW'(NGRP);

    sched_state_t  state, nxt;
    logic [IW-1:0] inflight;
    logic [GW-1:0] ret_cnt;
    logic          last_tile, take, ret, start_ok;

    // A credit is only needed to open a group; its remaining tiles never stall on credit.
    assign last_tile = rd_tile_o == LAST_T;
    assign rd_en_o   = state == ISSUE && tile_ready_i && (inflight < MAX_I || rd_tile_o != '0);
    assign take      = rd_en_o && rd_tile_o == '0;
    assign ret       = y_valid_i && inflight != '0;
    assign start_ok  = state == IDLE && start_i;
    assign busy_o    = state == ISSUE || state == DRAIN;
    assign done_o    = state == DONE;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start_i ? ISSUE : IDLE;
            ISSUE:   nxt = (rd_en_o && last_tile && rd_grp_o == LAST_G) ? DRAIN : ISSUE;
            DRAIN:   nxt = (ret_cnt == N_G) ? DONE : DRAIN;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_grp_o   <= '0;
            rd_tile_o  <= '0;
            inflight   <= '0;
            ret_cnt    <= '0;
            y_wr_en_o  <= 1'b0;
            y_wr_grp_o <= '0;
            err_o      <= 1'b0;
        end else begin
            rd_tile_o  <= start_ok ? '0 : rd_en_o ? (last_tile ? '0 : rd_tile_o + TW'(1)) : rd_tile_o;
            rd_grp_o   <= start_ok ? '0 : rd_grp_o + GW'(rd_en_o && last_tile);
            inflight   <= inflight + IW'(take) - IW'(ret);
            ret_cnt    <= start_ok ? '0 : ret_cnt + GW'(ret);
            y_wr_en_o  <= ret;
            y_wr_grp_o <= start_ok ? '0 : y_wr_grp_o + GW'(y_wr_en_o);
            err_o      <= err_o | (y_valid_i && inflight == '0);
        end
    end

    tile_vld_delay #(.LAT(RD_LAT)) u_dly (
        .clk  (clk),
        .rstn (rstn),
        .d    (rd_en_o),
        .q    (tile_valid_o)
    );
endmodule

// File: tb/tb_ssm_tile_sched.sv
// tb_ssm_tile_sched: two scheduler configurations driven against a cycle model of the SSM datapath
module tb_ssm_tile_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn[2], start[2], rdy[2], inj[2], ymodel[2], yv[2];
    logic rd_en[2], tv[2], busy[2], done[2], wr_en[2], err[2];
    logic [10:0] rg0, wg0;
    logic [0:0]  rt0;
    logic [4:0]  rg1, wg1;
    logic [2:0]  rt1;
    int rg[2], rt[2], wg[2];

    always_comb begin
        rg[0] = int'(rg0); rt[0] = int'(rt0); wg[0] = int'(wg0);
        rg[1] = int'(rg1); rt[1] = int'(rt1); wg[1] = int'(wg1);
    end
    assign yv[0] = ymodel[0] | inj[0];
    assign yv[1] = ymodel[1] | inj[1];

    ssm_tile_sched u0 (
        .clk(clk), .rstn(rstn[0]), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
        .rd_en_o(rd_en[0]), .rd_grp_o(rg0), .rd_tile_o(rt0), .tile_valid_o(tv[0]),
        .tile_ready_i(rdy[0]), .y_valid_i(yv[0]), .y_wr_en_o(wr_en[0]), .y_wr_grp_o(wg0),
        .err_o(err[0])
    );

    ssm_tile_sched #(.H_TOTAL(4), .P_TOTAL(4), .N_TILE(32), .N_TOTAL(128), .MAX_INFLIGHT(2)) u1 (
        .clk(clk), .rstn(rstn[1]), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
        .rd_en_o(rd_en[1]), .rd_grp_o(rg1), .rd_tile_o(rt1), .tile_valid_o(tv[1]),
        .tile_ready_i(rdy[1]), .y_valid_i(yv[1]), .y_wr_en_o(wr_en[1]), .y_wr_grp_o(wg1),
        .err_o(err[1])
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            if (failures <= 30) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int ng[2] = '{1536, 16};
    int tp[2] = '{1, 4};
    int mx[2] = '{4, 2};
    int dl[2] = '{40, 100};
    int running[2], out[2], grp[2], tile[2], retd[2], wrc[2], nrd[2], ndone[2];
    int rh[2], rtl[2], h1[2], h2[2], rd_p[2], yv_p[2], st_p[2], dpend[2], erre[2], rst_seen[2];
    int rq[2][8];
    int cy = 0;

    always @(negedge clk) begin
        int ret, take, dn, er;
        for (int k = 0; k < 2; k++) begin
            if (!rstn[k]) begin
                if (rst_seen[k] == 0) begin
                    chk("reset_outputs", int'({rd_en[k], tv[k], busy[k], done[k], wr_en[k], err[k]}), 0);
                    chk("reset_indices", rg[k] + rt[k] + wg[k], 0);
                    rst_seen[k] = 1;
                end
                running[k] = 0; out[k] = 0; erre[k] = 0; rh[k] = 0; rtl[k] = 0; rd_p[k] = 0;
                yv_p[k] = 0; st_p[k] = 0; h1[k] = 0; h2[k] = 0; dpend[k] = 0; ymodel[k] = 1'b0;
            end else begin
                rst_seen[k] = 0;
                ret  = int'(yv_p[k] != 0 && out[k] > 0);
                take = int'(rd_p[k] != 0 && tile[k] == 0);
                if (yv_p[k] != 0 && out[k] == 0) erre[k] = 1;
                chk("y_wr_en", int'(wr_en[k]), ret);
                if (ret != 0) begin
                    chk("y_wr_grp", wg[k], wrc[k]);
                    wrc[k]++;
                    retd[k]++;
                end
                out[k] += take - ret;
                if (rd_p[k] != 0) begin
                    nrd[k]++;
                    if (tile[k] == tp[k] - 1) begin tile[k] = 0; grp[k]++; end
                    else tile[k]++;
                end
                if (st_p[k] != 0 && running[k] == 0) begin
                    running[k] = 1; grp[k] = 0; tile[k] = 0; retd[k] = 0; wrc[k] = 0; nrd[k] = 0; ndone[k] = 0;
                end
                dn = dpend[k];
                dpend[k] = int'(ret != 0 && retd[k] == ng[k]);
                if (dn != 0) begin running[k] = 0; ndone[k]++; end
                chk("err", int'(err[k]), erre[k]);
                chk("busy", int'(busy[k]), running[k]);
                chk("done", int'(done[k]), dn);
                chk("tile_valid", int'(tv[k]), h2[k]);
                er = int'(running[k] != 0 && grp[k] < ng[k] && rdy[k] && (out[k] < mx[k] || tile[k] != 0));
                chk("rd_en", int'(rd_en[k]), er);
                if (er != 0) begin
                    chk("rd_grp", rg[k], grp[k]);
                    chk("rd_tile", rt[k], tile[k]);
                    if (tile[k] == tp[k] - 1) begin rq[k][rtl[k] % 8] = cy + dl[k]; rtl[k]++; end
                end
                h2[k] = h1[k]; h1[k] = er; rd_p[k] = er;
                if (rh[k] != rtl[k] && rq[k][rh[k] % 8] <= cy) begin ymodel[k] = 1'b1; rh[k]++; end
                else ymodel[k] = 1'b0;
                yv_p[k] = int'(ymodel[k] | inj[k]);
                st_p[k] = int'(start[k]);
            end
        end
        cy++;
    end

    task automatic pulse_start(input int k);
        @(posedge clk); #1 start[k] = 1'b1;
        @(posedge clk); #1 start[k] = 1'b0;
    endtask

    // g < 0 waits for done_o, otherwise for tile 1 of group g
    task automatic wait_sig(input string tag, input int k, input int g, input int lim);
        int i = 0;
        while (i < lim && !(g < 0 ? done[k] : (rg[k] == g && rt[k] == 1))) begin
            @(negedge clk);
            i++;
        end
        chk(tag, int'(i < lim), 1);
    endtask

    initial begin
        foreach (rstn[k]) begin rstn[k] = 1'b1; start[k] = 1'b0; rdy[k] = 1'b1; inj[k] = 1'b0; end
        #2 rstn[0] = 1'b0; rstn[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn[0] = 1'b1; rstn[1] = 1'b1;

        pulse_start(0);
        wait_sig("u0_done_timeout", 0, -1, 40000);
        repeat (4) @(posedge clk);
        chk("u0_reads", nrd[0], 1536);
        chk("u0_writes", wrc[0], 1536);
        chk("u0_dones", ndone[0], 1);
        chk("u0_err", int'(err[0]), 0);

        @(posedge clk); #1 inj[1] = 1'b1;
        @(posedge clk); #1 inj[1] = 1'b0;
        repeat (3) @(posedge clk);
        chk("u1_err_idle", int'(err[1]), 1);

        pulse_start(1);
        wait_sig("u1_grp3_timeout", 1, 3, 3000);
        @(posedge clk); #1 rdy[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy[1] = 1'b1;
        pulse_start(1);
        wait_sig("u1_done_timeout", 1, -1, 5000);
        repeat (4) @(posedge clk);
        chk("u1_reads", nrd[1], 64);
        chk("u1_writes", wrc[1], 16);
        chk("u1_dones", ndone[1], 1);
        chk("u1_err_sticky", int'(err[1]), 1);

        pulse_start(1);
        wait_sig("u1_grp10_timeout", 1, 10, 5000);
        @(posedge clk); #1 rstn[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn[1] = 1'b1;
        chk("u1_err_cleared", int'(err[1]), 0);
        pulse_start(1);
        wait_sig("u1_rerun_timeout", 1, -1, 5000);
        repeat (4) @(posedge clk);
        chk("u1_rerun_reads", nrd[1], 64);
        chk("u1_rerun_writes", wrc[1], 16);
        chk("u1_rerun_dones", ndone[1], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
